// File: rtl/logic_vector_checker_pkg.sv
// logic_vector_checker_pkg: shared definitions for the bitwise element checker.
// Op codes, LFSR seeds and taps, FSM encoding, and the reference op/step helpers.
package logic_vector_checker_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam logic [31:0] SEED_A    = 32'h0000FFFF;
    localparam logic [31:0] SEED_B    = 32'h00FF00FF;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] bitwise_op(
        input logic [1:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_vector_checker_lfsr32.sv
// lfsr32: 32-bit Galois LFSR with synchronous load and step enable.
// Ports: clk, rst (async high), load_i/seed_i (reload), en_i (step), state_o.
module lfsr32
    import logic_vector_checker_pkg::*;
#(
    parameter logic [31:0] RST_SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [31:0] seed_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (en_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/logic_vector_checker.sv
// logic_vector_checker: drives LFSR operand pairs into a 32-bit bitwise element
// and checks its result. Ports: clk, rst, start, op_sel in; op_a/op_b to element;
// dut_res from element; busy, done, pass, err_cnt, fail_valid, fail_idx status.
module logic_vector_checker
    import logic_vector_checker_pkg::*;
#(
    parameter int N_VEC  = 16,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op_sel,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic [31:0] dut_res,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic        fail_valid,
    output logic [7:0]  fail_idx
);

    localparam int IW = (N_VEC > 1) ? $clog2(N_VEC) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_VEC - 1);
    localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE - 1);

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [7:0]      err_q, err_d;
    logic            fv_q, fv_d;
    logic [7:0]      fidx_q, fidx_d;
    logic            load;
    logic            adv;
    logic            mismatch;
    logic [31:0]     lfsr_a;
    logic [31:0]     lfsr_b;

    lfsr32 #(.RST_SEED(SEED_A)) u_lfsr_a (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .en_i    (adv),
        .seed_i  (SEED_A),
        .state_o (lfsr_a)
    );

    lfsr32 #(.RST_SEED(SEED_B)) u_lfsr_b (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .en_i    (adv),
        .seed_i  (SEED_B),
        .state_o (lfsr_b)
    );

    // IDLE is only reachable through reset, so it alone shows zero operands;
    // from the first start on the operands track the LFSRs, DONE included.
    assign op_a = (state_q == ST_IDLE) ? 32'h0 : lfsr_a;
    assign op_b = (state_q == ST_IDLE) ? 32'h0 : lfsr_b;

    assign mismatch = bitwise_op(op_q, op_a, op_b) != dut_res;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fidx_d  = fidx_q;
        load    = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_d    = op_sel;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = 8'd0;
                    fv_d    = 1'b0;
                    fidx_d  = 8'd0;
                    load    = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SETTLE_END) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fidx_d = 8'(idx_q);
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    adv     = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 8'd0;
            fv_q    <= 1'b0;
            fidx_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fidx_q  <= fidx_d;
        end
    end

    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done       = (state_q == ST_DONE);
    assign pass       = done && (err_q == 8'd0);
    assign err_cnt    = err_q;
    assign fail_valid = fv_q;
    assign fail_idx   = fidx_q;

endmodule

// File: tb/tb_logic_vector_checker.sv
// tb_logic_vector_checker: emulates the bitwise element (with faults) and
// checks the checker's status against a table and a behavioural model.
module tb_logic_vector_checker;

    localparam int NV  = 16;
    localparam int ST  = 2;
    localparam int RUN = NV * (ST + 1);
    localparam logic [31:0] SA   = 32'h0000FFFF;
    localparam logic [31:0] SB   = 32'h00FF00FF;
    localparam logic [31:0] TAPS = 32'h80200003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op_sel = 2'b00;
    logic [31:0] op_a, op_b, dut_res;
    logic        busy, done, pass, fail_valid;
    logic [7:0]  err_cnt, fail_idx;

    logic        start2 = 1'b0;
    logic [31:0] op_a2, op_b2;
    logic        busy2, done2, pass2, fv2;
    logic [7:0]  err2, fidx2;

    logic [1:0]  elem = 2'b00;
    bit          stuck = 1'b0;
    bit          fault_en = 1'b0;
    logic [31:0] fa = '0, fb = '0;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    logic_vector_checker #(.N_VEC(NV), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sel(op_sel),
        .op_a(op_a), .op_b(op_b), .dut_res(dut_res),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_valid(fail_valid), .fail_idx(fail_idx)
    );

    logic_vector_checker #(.N_VEC(300), .SETTLE(ST)) dut_big (
        .clk(clk), .rst(rst), .start(start2), .op_sel(2'b01),
        .op_a(op_a2), .op_b(op_b2), .dut_res(32'h0),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .fail_valid(fv2), .fail_idx(fidx2)
    );

    function automatic logic [31:0] step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] fn(input logic [1:0] f,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        case (f)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Element under test: selected function, optional stuck-at-0 output,
    // optional bit-0 flip on one specific operand pair.
    always_comb begin
        dut_res = '0;
        if (!stuck) begin
            dut_res = fn(elem, op_a, op_b);
            if (fault_en && op_a == fa && op_b == fb) begin
                dut_res[0] = ~dut_res[0];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic model(input logic [1:0] op, input logic [1:0] el,
                         input int fi, input bit stk,
                         output int err, output bit fv, output int fidx);
        logic [31:0] a, b, exp, got;
        a = SA; b = SB; err = 0; fv = 0; fidx = 0;
        for (int i = 0; i < NV; i++) begin
            exp = fn(op, a, b);
            got = stk ? 32'h0 : (fn(el, a, b) ^ {31'b0, i == fi});
            if (got != exp) begin
                if (err < 255) err++;
                if (!fv) begin fv = 1; fidx = i; end
            end
            a = step(a);
            b = step(b);
        end
    endtask

    task automatic setup_elem(input logic [1:0] el, input int fi,
                              input bit stk);
        elem = el;
        stuck = stk;
        fault_en = (fi >= 0);
        fa = SA; fb = SB;
        for (int i = 0; i < fi; i++) begin
            fa = step(fa);
            fb = step(fb);
        end
    endtask

    task automatic run(input logic [1:0] op, input int abort_at,
                       input int poke_at);
        int cyc;
        bit seen;
        @(negedge clk);
        op_sel = op;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("op_a_seed", op_a, SA);
        chk("op_b_seed", op_b, SB);
        cyc = 0;
        seen = 0;
        while (cyc < 4 * RUN && !seen) begin
            @(posedge clk);
            #1 cyc++;
            if (cyc == 3) chk("op_a_step1", op_a, step(SA));
            if (poke_at != 0 && cyc == poke_at) start = 1'b1;
            if (poke_at != 0 && cyc == poke_at + 1) start = 1'b0;
            if (abort_at != 0 && cyc == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_outputs",
                    {op_a, op_b, busy, done, pass, fail_valid},
                    {32'h0, 32'h0, 4'b0} & 32'hFFFF_FFFF);
                chk("abort_op_a", op_a, 0);
                chk("abort_cnt", {16'h0, err_cnt, fail_idx}, 0);
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk);
                #1 chk("abort_idle", {busy, done}, 0);
                return;
            end
            if (done) seen = 1;
        end
        chk("done_cycle", cyc, RUN);
        chk("busy_at_done", busy, 0);
    endtask

    task automatic result(input string tag, input int err, input bit fv,
                          input int fidx);
        chk({tag, "_err"}, err_cnt, err);
        chk({tag, "_fv"}, fail_valid, fv);
        if (fv) chk({tag, "_fidx"}, fail_idx, fidx);
        chk({tag, "_pass"}, pass, err == 0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [1:0] el;
        int         fi;
        bit         stk;
        int         err;
        bit         fv;
        int         fidx;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   m_err, m_fidx;
        bit   m_fv;
        int   cyc;

        tbl[0] = '{2'd1, 2'd1, -1, 0, 0,  0, 0};
        tbl[1] = '{2'd0, 2'd0, -1, 0, 0,  0, 0};
        tbl[2] = '{2'd1, 2'd0, -1, 0, 16, 1, 0};
        tbl[3] = '{2'd1, 2'd1, -1, 1, 16, 1, 0};
        tbl[4] = '{2'd0, 2'd0, 5,  0, 1,  1, 5};
        tbl[5] = '{2'd2, 2'd2, -1, 0, 0,  0, 0};
        tbl[6] = '{2'd3, 2'd3, -1, 0, 0,  0, 0};
        tbl[7] = '{2'd3, 2'd3, 15, 0, 1,  1, 15};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ops", op_a | op_b, 0);
        chk("rst_flags", {busy, done, pass, fail_valid}, 0);
        chk("rst_cnt", {err_cnt, fail_idx}, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            setup_elem(tbl[i].el, tbl[i].fi, tbl[i].stk);
            run(tbl[i].op, 0, 0);
            result($sformatf("tbl%0d", i), tbl[i].err, tbl[i].fv,
                   tbl[i].fidx);
        end

        setup_elem(2'd1, -1, 1);
        run(2'd1, 20, 0);
        setup_elem(2'd1, -1, 0);
        run(2'd1, 0, 0);
        result("after_abort", 0, 0, 0);

        setup_elem(2'd2, 7, 0);
        run(2'd2, 0, 10);
        result("poke", 1, 1, 7);

        for (int r = 0; r < 10; r++) begin
            logic [1:0] op, el;
            int fi;
            bit stk;
            op = 2'($urandom_range(0, 3));
            el = ($urandom_range(0, 1) == 1) ? op : 2'($urandom_range(0, 3));
            fi = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NV - 1))
                                             : -1;
            stk = ($urandom_range(0, 7) == 0);
            setup_elem(el, fi, stk);
            model(op, el, fi, stk, m_err, m_fv, m_fidx);
            run(op, 0, 0);
            result($sformatf("rnd%0d", r), m_err, m_fv, m_fidx);
        end

        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        chk("big_seed", {op_a2 ^ SA} | {op_b2 ^ SB}, 0);
        cyc = 0;
        while (cyc < 2000 && !done2) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("big_done_cycle", cyc, 300 * (ST + 1));
        chk("big_err_sat", err2, 255);
        chk("big_fv", fv2, 1);
        chk("big_fidx", fidx2, 0);
        chk("big_pass", {busy2, pass2}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
